pipe_collision_scorer: RTL
==========================

Name: pipe_collision_scorer

Overview:
Consumes the pipe position stream (pipe_x, pipe_y) from the pipe generator and the bird's vertical position. It evaluates collision and pipe-pass events once per frame tick (move). It runs the game state machine (IDLE/PLAY/HIT) and maintains the current score and best score for the display logic. It sits between the pipe generator / bird physics blocks and the score/overlay renderer.

Parameters:
BIRD_X, 100, fixed left x of bird sprite (pixels)
BIRD_W, 24, bird width
BIRD_H, 24, bird height
PIPE_W, 60, pipe width
GAP_HALF, 80, half-height of pipe gap; gap centred on pipe_y
FLOOR_Y, 560, ground line; bird bottom at/below this is a hit
SCORE_MAX, 999, score saturation value

Ports:
clk  input  1  system clock
RESET_GAME_N  input  1  asynchronous active-low reset
move  input  1  frame tick, level signal in clk domain; rising edge = one frame
start  input  1  single-cycle start/restart request
bird_y  input  11  bird top y
pipe_x  input  11  pipe left x (wraps 0 -> 1023)
pipe_y  input  11  pipe gap centre y
state  output  2  00 IDLE, 01 PLAY, 10 HIT
collision  output  1  one-cycle pulse on the frame a hit is detected
game_over  output  1  high while in HIT
score  output  10  current score, binary
best_score  output  10  highest score since reset

Behaviour:
- Reset (async, RESET_GAME_N=0): state=IDLE; score=0; best_score=0; collision=0; game_over=0; passed=0; move_d=0.
- Frame detect: move_d registered each clk. frame = move & ~move_d. All evaluation happens on the cycle after the rising edge: inputs are sampled on the frame cycle and the outputs update on the next clk edge (latency 1).
- Arithmetic: all comparisons use 12-bit unsigned, zero-extended, so no wrap occurs. gap_top = (pipe_y < GAP_HALF) ? 0 : pipe_y - GAP_HALF. gap_bot = pipe_y + GAP_HALF.
- x_overlap = (pipe_x < BIRD_X+BIRD_W) && (pipe_x+PIPE_W > BIRD_X).
- hit = (x_overlap && (bird_y < gap_top || bird_y+BIRD_H > gap_bot)) || (bird_y+BIRD_H >= FLOOR_Y).
- Pass condition: pass = (pipe_x+PIPE_W <= BIRD_X) && !passed.
- Re-arm: passed clears when pipe_x >= BIRD_X+BIRD_W, i.e. the pipe has wrapped back to the right.
- IDLE:
  - start=1 -> PLAY; score=0; passed=0.
  - Frames are ignored.
- PLAY, on frame:
  - If hit: -> HIT; collision pulses for 1 clk; game_over=1; best_score=max(best_score, score) on the same edge.
  - Else if pass: score=min(score+1, SCORE_MAX); passed=1.
  - start is ignored in PLAY.
- HIT:
  - Score, best_score and passed are frozen; frames are ignored.
  - start=1 -> PLAY; score=0; passed=0; game_over=0.
- Simultaneous events:
  - hit and pass in the same frame: hit wins, no increment.
  - start coincident with a frame in IDLE/HIT: the transition to PLAY takes effect and that frame is not evaluated.
- Score saturates at SCORE_MAX and holds; passed still toggles normally.
- Reset mid-PLAY: immediate return to IDLE, all registers per reset list, including best_score.
- collision is never high outside the single cycle following a PLAY-frame hit.

Test Plan:
- Reset then start, with pipe_x=110, pipe_y=300, bird_y=290, one move rise -> state=PLAY; collision=0; score=0 (bird 290..314 inside gap 220..380).
- In PLAY, pipe_x=110, pipe_y=300, bird_y=200, move rise -> collision pulses 1 clk; state=HIT; game_over=1; best_score=score.
- Pipe_x stepped 45 then 39 over successive frames, bird in gap -> score 0 after 45, 1 after 39. Further frames at 36, 33 -> score stays 1. Pipe_x=1023, then back down to 39 -> score=2.
- bird_y=536 with pipe_x=500 (no x overlap) -> hit via floor (536+24=560); state=HIT.
- Score preloaded by 999 passes -> score holds 999 on the next pass, no wrap. Then a hit -> best_score=999. start -> score=0, best_score=999.
- Assert RESET_GAME_N low mid-PLAY with score=5 -> same cycle: state=IDLE, score=0, best_score=0, game_over=0. Frames in IDLE leave all outputs unchanged.

Source files
------------

// File: rtl/pipe_collision_scorer.sv
// -----------------------------------------------------------------------------
// pipe_collision_scorer
//
// Purpose:
//   Once per frame (rising edge of `move`), this block checks the bird against
//   the current pipe and the floor. It runs the IDLE/PLAY/HIT game state
//   machine and keeps the current score and the best score for the overlay
//   renderer. Results appear on the clock edge that ends the frame cycle, so
//   the latency is one clock.
//
// Ports:
//   clk          in   1   system clock
//   RESET_GAME_N in   1   asynchronous active-low reset
//   move         in   1   frame tick level; a rising edge marks one frame
//   start        in   1   single-cycle start/restart request
//   bird_y       in  11   bird sprite top y
//   pipe_x       in  11   pipe left x (wraps from 0 back to 1023)
//   pipe_y       in  11   pipe gap centre y
//   state        out  2   00 IDLE, 01 PLAY, 10 HIT
//   collision    out  1   one-clock pulse after a PLAY frame that hit
//   game_over    out  1   high while in HIT
//   score        out 10   current score (saturates at SCORE_MAX)
//   best_score   out 10   highest score since reset
// -----------------------------------------------------------------------------
module pipe_collision_scorer #(
   parameter int unsigned BIRD_X    = 100,
   parameter int unsigned BIRD_W    = 24,
   parameter int unsigned BIRD_H    = 24,
   parameter int unsigned PIPE_W    = 60,
   parameter int unsigned GAP_HALF  = 80,
   parameter int unsigned FLOOR_Y   = 560,
   parameter int unsigned SCORE_MAX = 999
) (
   input  logic        clk,
   input  logic        RESET_GAME_N,
   input  logic        move,
   input  logic        start,
   input  logic [10:0] bird_y,
   input  logic [10:0] pipe_x,
   input  logic [10:0] pipe_y,
   output logic [1:0]  state,
   output logic        collision,
   output logic        game_over,
   output logic [9:0]  score,
   output logic [9:0]  best_score
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_HIT  = 2'b10
   } state_t;

   // Geometry is compared in 12 bits so that sums such as pipe_x + PIPE_W
   // never wrap.
   localparam logic [11:0] BIRD_X_C    = 12'(BIRD_X);
   localparam logic [11:0] BIRD_W_C    = 12'(BIRD_W);
   localparam logic [11:0] BIRD_H_C    = 12'(BIRD_H);
   localparam logic [11:0] PIPE_W_C    = 12'(PIPE_W);
   localparam logic [11:0] GAP_HALF_C  = 12'(GAP_HALF);
   localparam logic [11:0] FLOOR_Y_C   = 12'(FLOOR_Y);
   localparam logic [11:0] BIRD_R_C    = 12'(BIRD_X + BIRD_W);
   localparam logic [9:0]  SCORE_MAX_C = 10'(SCORE_MAX);

   // Saturating score increment.
   function automatic logic [9:0] sat_inc(input logic [9:0] v);
      if (v >= SCORE_MAX_C) begin
         return SCORE_MAX_C;
      end else begin
         return v + 10'd1;
      end
   endfunction

   // Larger of two scores.
   function automatic logic [9:0] max10(input logic [9:0] a, input logic [9:0] b);
      if (a >= b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

   state_t      state_q, state_d;
   logic        move_q;
   logic        collision_q, collision_d;
   logic        game_over_q, game_over_d;
   logic        passed_q, passed_d;
   logic [9:0]  score_q, score_d;
   logic [9:0]  best_q, best_d;

   logic        frame_s;
   logic [11:0] bird_y_s, bird_bot_s, pipe_x_s, pipe_r_s, pipe_y_s;
   logic [11:0] gap_top_s, gap_bot_s;
   logic        x_overlap_s, hit_s, pass_s, rearm_s;

   // Geometry and event decode for the current frame inputs.
   always_comb begin
      frame_s   = move & ~move_q;
      bird_y_s  = {1'b0, bird_y};
      pipe_x_s  = {1'b0, pipe_x};
      pipe_y_s  = {1'b0, pipe_y};
      bird_bot_s = bird_y_s + BIRD_H_C;
      pipe_r_s  = pipe_x_s + PIPE_W_C;
      gap_bot_s = pipe_y_s + GAP_HALF_C;
      if (pipe_y_s < GAP_HALF_C) begin
         gap_top_s = 12'd0;
      end else begin
         gap_top_s = pipe_y_s - GAP_HALF_C;
      end
      x_overlap_s = (pipe_x_s < BIRD_R_C) && (pipe_r_s > BIRD_X_C);
      hit_s = (x_overlap_s && ((bird_y_s < gap_top_s) || (bird_bot_s > gap_bot_s)))
              || (bird_bot_s >= FLOOR_Y_C);
      pass_s  = (pipe_r_s <= BIRD_X_C) && !passed_q;
      // The pipe is fully to the right of the bird again after wrapping.
      rearm_s = (pipe_x_s >= BIRD_R_C);
   end

   // Next-state logic for the game FSM and the score registers.
   always_comb begin
      state_d     = state_q;
      score_d     = score_q;
      best_d      = best_q;
      passed_d    = passed_q;
      game_over_d = game_over_q;
      collision_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A frame that arrives with start is skipped.
            if (start) begin
               state_d     = ST_PLAY;
               score_d     = 10'd0;
               passed_d    = 1'b0;
               game_over_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PLAY: begin
            if (frame_s) begin
               if (hit_s) begin
                  // A hit takes priority over a pass in the same frame.
                  state_d     = ST_HIT;
                  collision_d = 1'b1;
                  game_over_d = 1'b1;
                  best_d      = max10(best_q, score_q);
               end else if (pass_s) begin
                  score_d  = sat_inc(score_q);
                  passed_d = 1'b1;
               end else if (rearm_s) begin
                  passed_d = 1'b0;
               end else begin
                  passed_d = passed_q;
               end
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_HIT: begin
            if (start) begin
               state_d     = ST_PLAY;
               score_d     = 10'd0;
               passed_d    = 1'b0;
               game_over_d = 1'b0;
            end else begin
               state_d = ST_HIT;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            score_d     = 10'd0;
            passed_d    = 1'b0;
            game_over_d = 1'b0;
         end
      endcase
   end

   // State, score and frame-edge registers.
   always_ff @(posedge clk or negedge RESET_GAME_N) begin
      if (!RESET_GAME_N) begin
         state_q     <= ST_IDLE;
         move_q      <= 1'b0;
         collision_q <= 1'b0;
         game_over_q <= 1'b0;
         passed_q    <= 1'b0;
         score_q     <= 10'd0;
         best_q      <= 10'd0;
      end else begin
         state_q     <= state_d;
         move_q      <= move;
         collision_q <= collision_d;
         game_over_q <= game_over_d;
         passed_q    <= passed_d;
         score_q     <= score_d;
         best_q      <= best_d;
      end
   end

   assign state      = state_q;
   assign collision  = collision_q;
   assign game_over  = game_over_q;
   assign score      = score_q;
   assign best_score = best_q;

endmodule
